inst_fetcher: RTL and testbench

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher.sv | 175 +++++++++++++++++
 tb/tb_inst_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
//   Byte-serial instruction fetch unit. Fetches 32-bit little-endian words one
//   byte at a time through a shared memory arbiter and buffers completed words
//   in a small queue for the decoder. Only one instruction is in flight at a
//   time. With continuous grants a new fetch starts in the same cycle the last
//   byte of the previous one arrives, so throughput is one word per 4 cycles.
//
// Parameters
//   RESET_PC     fetch address after reset
//   QUEUE_DEPTH  instruction queue entries (power of 2, >= 2)
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          synchronous reset, active high
//   rdy_in          global enable, low = stall
//   redirect_valid  flush queue and restart fetch at redirect_pc
//   redirect_pc     new fetch address (not realigned)
//   mem_req         byte read request to the arbiter
//   mem_addr        byte address of the request
//   mem_grant       arbiter accepted mem_addr this cycle
//   mem_din         data for the address granted in the previous cycle
//   out_valid       queue head holds a complete instruction
//   out_inst        head instruction word
//   out_pc          address of the head instruction
//   out_ready       decoder accepts the head this cycle
// -----------------------------------------------------------------------------
module inst_fetcher #(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_grant,
  input  logic [7:0]  mem_din,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t          state;
  logic [31:0]     fetch_pc;
  logic [2:0]      issue_idx;   // bytes granted for the current word (0..4)
  logic [2:0]      rcv_idx;     // bytes received for the current word (0..4)
  logic            byte_due;    // a grant last cycle means mem_din is live now
  logic [31:0]     inst;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_inst [QUEUE_DEPTH];
  logic [31:0]     q_pc   [QUEUE_DEPTH];

  logic        run;
  logic        done;
  logic        deq;
  logic        slot_free;
  logic        grant;
  logic [31:0] asm_inst;

  // Redirect wins over every other action of an active cycle.
  assign run  = rdy_in && !redirect_valid;
  // Word completes when byte 3 arrives, or on the first active cycle after it
  // was captured during a stall.
  assign done = run && (state == FETCH) &&
                ((rcv_idx == 3'd4) || (byte_due && rcv_idx == 3'd3));
  assign deq  = run && out_valid && out_ready;
  // A new fetch reserves a slot: occupancy after this cycle's enqueue and
  // dequeue must leave room for it.
  assign slot_free = (int'(count) + 1 - int'(deq)) < QUEUE_DEPTH;

  // While the last byte arrives, the next word's byte 0 may already be issued;
  // its address is fetch_pc + 4, which is exactly fetch_pc + issue_idx.
  assign mem_req  = run && (state == FETCH) &&
                    ((issue_idx < 3'd4) || (done && slot_free));
  assign mem_addr = fetch_pc + {29'd0, issue_idx};
  assign grant    = mem_req && mem_grant;

  assign out_valid = (count != '0);
  assign out_inst  = out_valid ? q_inst[rd_ptr] : '0;
  assign out_pc    = out_valid ? q_pc[rd_ptr]   : '0;

  // Current word with the arriving byte merged in at its little-endian lane.
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps paths that skip an
    // assignment from inferring a latch.
    asm_inst = inst;
    if (byte_due && !rcv_idx[2]) begin
      case (rcv_idx[1:0])
        2'd0: asm_inst[7:0]   = mem_din;
        2'd1: asm_inst[15:8]  = mem_din;
        2'd2: asm_inst[23:16] = mem_din;
        2'd3: asm_inst[31:24] = mem_din;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      issue_idx <= '0;
      rcv_idx   <= '0;
      byte_due  <= 1'b0;   // drops any byte returning after reset
      inst      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else if (!rdy_in) begin
      // Stalled: everything holds, but a byte already on its way is kept.
      byte_due <= 1'b0;
      if (byte_due && !rcv_idx[2]) begin
        inst    <= asm_inst;
        rcv_idx <= rcv_idx + 3'd1;
      end
    end else if (redirect_valid) begin
      state     <= IDLE;
      fetch_pc  <= redirect_pc;
      issue_idx <= '0;
      rcv_idx   <= '0;
      byte_due  <= 1'b0;   // the byte returning in this cycle is discarded
      inst      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      byte_due <= grant;
      if (done) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
        rcv_idx  <= '0;
        inst     <= '0;
        if (slot_free) begin
          state     <= FETCH;
          issue_idx <= grant ? 3'd1 : 3'd0;
        end else begin
          state     <= IDLE;
          issue_idx <= '0;
        end
      end else begin
        if (byte_due) begin
          inst    <= asm_inst;
          rcv_idx <= rcv_idx + 3'd1;
        end
        if (grant) issue_idx <= issue_idx + 3'd1;
        if (state == IDLE && int'(count) < QUEUE_DEPTH) state <= FETCH;
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      if (done && !deq)      count <= count + CW'(1);
      else if (!done && deq) count <= count - CW'(1);
    end
  end

  // NOTE: queue storage is not reset; entries are only visible through
  // out_valid, and the outputs are forced to zero while the queue is empty.
  always_ff @(posedge clk_in) begin
    if (!rst_in && done) begin
      q_inst[wr_ptr] <= asm_inst;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// -----------------------------------------------------------------------------
// tb_inst_fetcher
//   Directed timing scenarios plus randomized traffic for inst_fetcher. A
//   transaction-level reference model tracks the expected byte address stream
//   and the queue of completed {inst, pc} pairs; it is updated at every falling
//   edge from the inputs of that cycle.
// -----------------------------------------------------------------------------
module tb_inst_fetcher;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant = 1'b0;
  logic [7:0]  mem_din = '0;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready = 1'b0;

  inst_fetcher #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_grant(mem_grant),
    .mem_din(mem_din), .out_valid(out_valid), .out_inst(out_inst),
    .out_pc(out_pc), .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents: fixed program bytes at 0..3, a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] t;
    case (a)
      32'd0: return 8'h13;
      32'd1: return 8'h05;
      32'd2: return 8'h10;
      32'd3: return 8'h00;
      default: begin
        t = a[7:0] * 8'd7;
        return t ^ a[15:8] ^ a[31:24] ^ 8'hA5;
      end
    endcase
  endfunction

  // ---------------- memory responder ----------------
  logic        resp_valid = 1'b0;
  logic [31:0] resp_addr  = '0;

  always @(posedge clk_in) begin
    #1;
    mem_din = resp_valid ? mem_byte(resp_addr) : 8'($urandom);
  end

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        exp_q[$];
  bit          model_on  = 1'b0;
  logic [31:0] m_base    = '0;
  int          m_off     = 0;
  logic [31:0] m_word    = '0;
  bit          pend_done = 1'b0;
  ent_t        pend_ent;
  int          n_popped  = 0;

  always @(negedge clk_in) begin
    if (model_on) begin
      check("out_valid", out_valid, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("head_inst", out_inst, exp_q[0].inst);
        check("head_pc", out_pc, exp_q[0].pc);
      end
    end
    resp_valid = mem_req && mem_grant;
    resp_addr  = mem_addr;
    if (rst_in) begin
      model_on  = 1'b1;
      exp_q.delete();
      m_base    = 32'h0;
      m_off     = 0;
      m_word    = '0;
      pend_done = 1'b0;
    end else if (model_on) begin
      if (!rdy_in) begin
        check("req_in_stall", mem_req, 0);
      end else if (redirect_valid) begin
        exp_q.delete();
        m_base    = redirect_pc;
        m_off     = 0;
        m_word    = '0;
        pend_done = 1'b0;
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_popped++;
        end
        if (pend_done) begin
          exp_q.push_back(pend_ent);
          pend_done = 1'b0;
        end
        if (mem_req && mem_grant) begin
          check("room_for_fetch", 32'(exp_q.size() < DEPTH), 1);
          check("grant_addr", mem_addr, m_base + 32'(m_off));
          m_word = {mem_byte(m_base + 32'(m_off)), m_word[31:8]};
          m_off++;
          if (m_off == 4) begin
            pend_done     = 1'b1;
            pend_ent.inst = m_word;
            pend_ent.pc   = m_base;
            m_base        = m_base + 32'd4;
            m_off         = 0;
            m_word        = '0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; redirect_valid = 1'b0;
    mem_grant = 1'b0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst_in = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle with mem_req high.
  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      sample();
      if (mem_req) return;
      next_cycle();
    end
    check(tag, 0, 1);
  endtask

  int hi_cnt;
  logic [31:0] w100;

  initial begin
    // ---- basic fetch timing, then queue-full backpressure ----
    do_reset();
    mem_grant = 1'b1;
    wait_req("a_req_timeout");
    for (int k = 0; k < 4; k++) begin
      check("a_addr", mem_addr, 32'(k));
      next_cycle();
      sample();
    end
    check("a_valid_t4", out_valid, 0);
    next_cycle();
    sample();
    check("a_valid_t5", out_valid, 1);
    check("a_inst_t5", out_inst, 32'h00100513);
    check("a_pc_t5", out_pc, 32'h0);

    for (int k = 0; k < 5; k++) next_cycle();
    hi_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      sample();
      if (mem_req) hi_cnt++;
    end
    check("b_full_no_req", hi_cnt, 0);
    check("b_head_pc", out_pc, 32'h0);
    next_cycle();
    out_ready = 1'b1;
    sample();
    next_cycle();
    out_ready = 1'b0;
    sample();
    check("b_head_pc_after_pop", out_pc, 32'h4);
    wait_req("b_resume_timeout");
    check("b_resume_addr", mem_addr, 32'h8);

    // ---- redirect after two granted bytes ----
    do_reset();
    mem_grant = 1'b1; out_ready = 1'b1;
    wait_req("c_req_timeout");
    check("c_addr0", mem_addr, 32'h0);
    next_cycle();
    sample();
    check("c_addr1", mem_addr, 32'h1);
    next_cycle();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    sample();
    next_cycle();
    redirect_valid = 1'b0;
    sample();
    check("c_valid_after_redirect", out_valid, 0);
    wait_req("c_req2_timeout");
    check("c_redirect_addr", mem_addr, 32'h100);
    w100 = {mem_byte(32'h103), mem_byte(32'h102), mem_byte(32'h101), mem_byte(32'h100)};
    for (int k = 0; k < 10 && !out_valid; k++) begin
      next_cycle();
      sample();
    end
    check("c_out_pc", out_pc, 32'h100);
    check("c_out_inst", out_inst, w100);

    // ---- alternating grants ----
    do_reset();
    mem_grant = 1'b1; out_ready = 1'b0;
    wait_req("d_req_timeout");
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      mem_grant = (c % 2 == 0);
      sample();
      if (c <= 6) check("d_addr", mem_addr, 32'((c + 1) / 2));
      if (c == 7) check("d_valid_t7", out_valid, 0);
      if (c == 8) begin
        check("d_valid_t8", out_valid, 1);
        check("d_inst_t8", out_inst, 32'h00100513);
      end
    end

    // ---- redirect near the top of the address space ----
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    sample();
    next_cycle();
    redirect_valid = 1'b0; mem_grant = 1'b1; out_ready = 1'b1;
    wait_req("e_req_timeout");
    for (int k = 0; k < 10; k++) begin
      if (k < 8) check("e_addr", mem_addr, 32'hFFFF_FFFC + 32'(k));
      if (k == 5) begin
        check("e_valid_t5", out_valid, 1);
        check("e_pc_t5", out_pc, 32'hFFFF_FFFC);
      end
      if (k == 9) begin
        check("e_valid_t9", out_valid, 1);
        check("e_pc_t9", out_pc, 32'h0);
      end
      next_cycle();
      sample();
    end

    // ---- reset in the middle of a fetch ----
    do_reset();
    mem_grant = 1'b1; out_ready = 1'b1;
    wait_req("f_req_timeout");
    next_cycle();
    sample();
    check("f_addr1", mem_addr, 32'h1);
    next_cycle();
    rst_in = 1'b1;
    sample();
    next_cycle();
    rst_in = 1'b0;
    sample();
    check("f_rst_valid", out_valid, 0);
    check("f_rst_inst", out_inst, 0);
    check("f_rst_pc", out_pc, 0);
    check("f_rst_req", mem_req, 0);
    check("f_rst_addr", mem_addr, 32'h0);
    next_cycle();
    sample();
    check("f_restart_req", mem_req, 1);
    check("f_restart_addr", mem_addr, 32'h0);
    hi_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      sample();
      if (out_valid) hi_cnt++;
    end
    check("f_no_enqueue", hi_cnt, 0);
    next_cycle();
    sample();
    check("f_new_valid", out_valid, 1);
    check("f_new_pc", out_pc, 32'h0);

    // ---- randomized traffic ----
    do_reset();
    n_popped = 0;
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst_in         = ($urandom_range(999) < 5);
      rdy_in         = ($urandom_range(99) < 85);
      mem_grant      = ($urandom_range(99) < 70);
      out_ready      = ($urandom_range(99) < 50);
      redirect_valid = ($urandom_range(99) < 3);
      redirect_pc    = ($urandom_range(1) == 0) ? $urandom
                                                : 32'hFFFF_FFF0 + 32'($urandom_range(15));
    end
    next_cycle();
    rst_in = 1'b0; redirect_valid = 1'b0;
    sample();
    check("rand_progress", 32'(n_popped > 20), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
